cavlc_level_bitgen: RTL and testbench

Parametrised CAVLC level-codeword generator for the Level stage of the H.264 entropy encoder. It converts one `level_code` / `suffix_len` pair from the level controller into the complete level_prefix + level_suffix bitstring, including both escape forms (prefix 14 and prefix 15), and serialises it MSB-first into the bitstream FIFO. A valid/ready handshake is used on both sides, so FIFO backpressure stalls the block without losing bits.

---
 rtl/cavlc_level_bitgen_if.sv | 10 +
 rtl/cavlc_level_bitgen.sv | 117 +++++++++++
 tb/tb_cavlc_level_bitgen.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/cavlc_level_bitgen_if.sv
// cavlc_level_bitgen_if: handshake bundle between level controller, codeword generator and bitstream FIFO
interface cavlc_level_bitgen_if #(parameter int DATA_W = 16);
  logic in_valid, in_ready, out_valid, out_ready, out_bit, done, busy, err;
  logic [DATA_W-1:0] level_code;
  logic [2:0] suffix_len;
  modport master(output in_valid, level_code, suffix_len, out_ready,
                 input in_ready, out_valid, out_bit, done, busy, err);
  modport slave(input in_valid, level_code, suffix_len, out_ready,
                output in_ready, out_valid, out_bit, done, busy, err);
endinterface

// File: rtl/cavlc_level_bitgen.sv
// cavlc_level_bitgen: CAVLC level_prefix/level_suffix serialiser, MSB-first, valid/ready on both sides.
// Define CAVLC_LEVEL_PREFIX16_EN to encode prefix-15 overflows as prefix 16 instead of saturating.
module cavlc_level_bitgen #(
  parameter int DATA_W = 16,
  parameter int SUF_W = 13
) (
  input logic clk,
  input logic rst,
  cavlc_level_bitgen_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CALC, PREFIX, SUFFIX, DONE} state_t;
  state_t state;
  logic [DATA_W-1:0] lc;
  logic [2:0] sl;
  logic [4:0] prefix, cnt, c_prefix;
  logic [3:0] size, c_size;
  logic [SUF_W-1:0] sreg, c_suf;
  logic [31:0] lc32, p, diff;
  logic esc, c_err;
  always_comb begin
    lc32 = 32'(lc);
    p = lc32 >> sl;
    esc = sl == 3'd0 ? lc32 >= 32'd30 : p >= 32'd15;
    diff = sl == 3'd0 ? lc32 - 32'd30 : lc32 - (32'd15 << sl);
    c_prefix = 5'd15;
    c_size = 4'd12;
    c_suf = SUF_W'(diff);
    c_err = 1'b0;
    if (!esc) begin
      c_prefix = sl == 3'd0 ? (lc32 < 32'd14 ? 5'(lc32) : 5'd14) : 5'(p);
      c_size = sl == 3'd0 ? (lc32 < 32'd14 ? 4'd0 : 4'd4) : {1'b0, sl};
      c_suf = sl == 3'd0 ? SUF_W'(lc32 - 32'd14) : SUF_W'(lc32 & ((32'd1 << sl) - 32'd1));
    end else if (diff >= 32'd4096) begin
`ifdef CAVLC_LEVEL_PREFIX16_EN
      c_prefix = 5'd16;
      c_size = 4'd13;
      c_err = diff >= 32'd12288;
      c_suf = c_err ? SUF_W'(13'h1fff) : SUF_W'(diff - 32'd4096);
`else
      c_suf = SUF_W'(12'hfff);
      c_err = 1'b1;
`endif
    end
  end
  // Suffix is left-aligned in sreg so emission is always from the top bit.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      bus.in_ready <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_bit <= 1'b0;
      bus.done <= 1'b0;
      bus.busy <= 1'b0;
      bus.err <= 1'b0;
      lc <= '0;
      sl <= '0;
      prefix <= '0;
      size <= '0;
      sreg <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          lc <= bus.level_code;
          sl <= &bus.suffix_len ? 3'd6 : bus.suffix_len;
          bus.err <= &bus.suffix_len;
          bus.in_ready <= 1'b0;
          bus.busy <= 1'b1;
          state <= CALC;
        end
        CALC: begin
          prefix <= c_prefix;
          size <= c_size;
          sreg <= c_suf << (SUF_W - int'(c_size));
          bus.err <= bus.err | c_err;
          cnt <= '0;
          state <= PREFIX;
        end
        PREFIX: if (!bus.out_valid) begin
          bus.out_valid <= 1'b1;
          bus.out_bit <= prefix == 5'd0;
        end else if (bus.out_ready) begin
          if (cnt != prefix) begin
            cnt <= cnt + 5'd1;
            bus.out_bit <= cnt + 5'd1 == prefix;
          end else if (size != 4'd0) begin
            cnt <= 5'(size) - 5'd1;
            bus.out_bit <= sreg[SUF_W-1];
            sreg <= sreg << 1;
            state <= SUFFIX;
          end else begin
            bus.out_valid <= 1'b0;
            bus.done <= 1'b1;
            state <= DONE;
          end
        end
        SUFFIX: if (bus.out_ready) begin
          if (cnt != 5'd0) begin
            cnt <= cnt - 5'd1;
            bus.out_bit <= sreg[SUF_W-1];
            sreg <= sreg << 1;
          end else begin
            bus.out_valid <= 1'b0;
            bus.done <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          bus.out_bit <= 1'b0;
          bus.in_ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_cavlc_level_bitgen.sv
// tb_cavlc_level_bitgen: directed and random words checked against an arithmetic codeword model,
// including backpressure, busy-time input noise and mid-word reset.
module tb_cavlc_level_bitgen;
  localparam int DATA_W = 16;
  logic clk = 1'b0, rst = 1'b0;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  cavlc_level_bitgen_if #(.DATA_W(DATA_W)) bus();
  cavlc_level_bitgen #(.DATA_W(DATA_W), .SUF_W(13)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Codeword as: nbits total, v = '1' marker followed by the suffix (leading zeros implied by nbits).
  function automatic void model(input int lc, input int sl_in, output int nbits, output logic [31:0] v, output bit e);
    int sl, pre, sz, suf;
    e = sl_in == 7;
    sl = e ? 6 : sl_in;
    if (sl == 0 && lc < 14) begin pre = lc; sz = 0; suf = 0; end
    else if (sl == 0 && lc < 30) begin pre = 14; sz = 4; suf = lc - 14; end
    else if (sl > 0 && (lc >> sl) < 15) begin pre = lc >> sl; sz = sl; suf = lc % (1 << sl); end
    else begin
      pre = 15; sz = 12;
      suf = lc - ((15 << sl) + (sl == 0 ? 15 : 0));
      if (suf >= 4096) begin
`ifdef CAVLC_LEVEL_PREFIX16_EN
        pre = 16; sz = 13; suf = suf - 4096;
        if (suf >= 8192) begin e = 1; suf = 8191; end
`else
        suf = 4095; e = 1;
`endif
      end
    end
    nbits = pre + 1 + sz;
    v = (32'd1 << sz) | 32'(suf);
  endfunction

  task automatic run_word(input int lc, input int sl, input int mode, input int abort_at, input bit garbage);
    int nb_exp, nb, cyc, first_v;
    logic [31:0] v_exp, v;
    bit e_exp, pv, pb, pr;
    bit pat[6] = '{1, 0, 0, 1, 0, 1};
    model(lc, sl, nb_exp, v_exp, e_exp);
    check("in_ready_idle", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.level_code = DATA_W'(lc);
    bus.suffix_len = 3'(sl);
    @(negedge clk);
    bus.in_valid = garbage;
    bus.level_code = DATA_W'($urandom);
    bus.suffix_len = 3'($urandom);
    check("busy_calc", bus.busy, 1);
    check("in_ready_busy", bus.in_ready, 0);
    nb = 0; v = 0; cyc = 1; first_v = 0; pv = 0; pb = 0; pr = 0;
    forever begin
      if (abort_at != 0 && nb == abort_at) return;
      if (pv && !pr) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_bit", bus.out_bit, pb);
      end
      if (bus.done) break;
      if (cyc > 300) begin
        n_cmp++; n_bad++;
        $error("FAIL timeout observed=%0d cycles expected=done pulse", cyc);
        break;
      end
      if (bus.out_valid && first_v == 0) first_v = cyc;
      bus.out_ready = mode == 0 ? 1'b1 : mode == 1 ? pat[cyc % 6] : 1'($urandom_range(0, 1));
      pv = bus.out_valid; pb = bus.out_bit; pr = bus.out_ready;
      if (pv && pr) begin v = {v[30:0], pb}; nb++; end
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
    check($sformatf("nbits lc=%0d sl=%0d", lc, sl), nb, nb_exp);
    check($sformatf("bits lc=%0d sl=%0d", lc, sl), v, v_exp);
    check($sformatf("err lc=%0d sl=%0d", lc, sl), bus.err, e_exp);
    if (mode == 0) begin
      check("first_bit_latency", first_v, 3);
      check("done_latency", cyc, nb_exp + 3);
    end
    @(negedge clk);
    check("done_one_cycle", bus.done, 0);
    check("in_ready_after", bus.in_ready, 1);
    check("busy_after", bus.busy, 0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.level_code = '0;
    bus.suffix_len = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_bit", bus.out_bit, 0);
    check("rst_done", bus.done, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_err", bus.err, 0);
    run_word(5, 0, 0, 0, 0);
    run_word(20, 0, 0, 0, 1);
    run_word(13, 2, 0, 0, 0);
    run_word(40, 1, 0, 0, 1);
    run_word(13, 2, 1, 0, 0);
    run_word(5000, 0, 0, 0, 0);
    run_word(100, 7, 0, 0, 0);
    run_word(29, 0, 1, 0, 0);
    run_word(959, 6, 2, 0, 1);
    run_word(65535, 6, 0, 0, 0);
    run_word(20, 0, 0, 3, 0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_out_bit", bus.out_bit, 0);
    check("mid_rst_err", bus.err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      check("post_rst_no_bits", bus.out_valid, 0);
      @(negedge clk);
    end
    run_word(5, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      int r, lc;
      r = $urandom_range(0, 3);
      lc = r == 0 ? $urandom_range(0, 40) : r == 1 ? $urandom_range(0, 1000) :
           r == 2 ? $urandom_range(0, 6000) : $urandom_range(0, 65535);
      run_word(lc, $urandom_range(0, 7), $urandom_range(0, 2), 0, 1'($urandom_range(0, 1)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
